// File: rtl/pa_pkg.sv
// -----------------------------------------------------------------------------
// pa_pkg
// Shared definitions for the extended-format adder operand paths: operand
// width, the 2-bit path codes used by both the demux and the merge, and the
// packed operand-pair type that travels down each alignment path.
// -----------------------------------------------------------------------------
package pa_pkg;

    // sign + exponent + extended mantissa
    localparam int W = 37;

    localparam logic [1:0] TAG_P0  = 2'b00;
    localparam logic [1:0] TAG_P1  = 2'b01;
    localparam logic [1:0] TAG_P2  = 2'b10;
    localparam logic [1:0] TAG_INV = 2'b11;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pa_pair_t;

endpackage

// File: rtl/pa_tag_fifo.sv
// -----------------------------------------------------------------------------
// pa_tag_fifo
// Small FIFO of 2-bit path codes recording the order in which operations were
// issued to the alignment paths.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push, din   write din at the tail (ignored when full)
//   pop         drop the head entry (ignored when empty)
//   head        path code at the head of the FIFO
//   empty, full status flags
//   count       number of entries held (0..DEPTH)
// -----------------------------------------------------------------------------
module pa_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [1:0]    din,
    output logic [1:0]    head,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers are AW bits and wrap naturally; count separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pa_path_merge.sv
// -----------------------------------------------------------------------------
// pa_path_merge
// Merges the results of the three operand alignment paths back onto a single
// valid/ready stream in issue order. Each issue at the demux pushes its path
// code into a tag FIFO; the merge only accepts from the path named at the FIFO
// head, so results on different paths can never overtake one another.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   iss_valid, iss_tag         issue at the demux and its path code
//   iss_ready                  tag FIFO has room
//   pN_valid/pN_ready/pN_a/b   result stream from path N (N = 0..2)
//   out_valid/out_ready        merged result handshake
//   out_a, out_b, out_tag      merged operand pair and its source path
//   occupancy                  outstanding tags
//   tag_err                    sticky: an issue carried the invalid code
// -----------------------------------------------------------------------------
module pa_path_merge
    import pa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iss_valid,
    input  logic [1:0]    iss_tag,
    output logic          iss_ready,
    input  logic          p0_valid,
    input  logic          p1_valid,
    input  logic          p2_valid,
    output logic          p0_ready,
    output logic          p1_ready,
    output logic          p2_ready,
    input  logic [W-1:0]  p0_a,
    input  logic [W-1:0]  p0_b,
    input  logic [W-1:0]  p1_a,
    input  logic [W-1:0]  p1_b,
    input  logic [W-1:0]  p2_a,
    input  logic [W-1:0]  p2_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_a,
    output logic [W-1:0]  out_b,
    output logic [1:0]    out_tag,
    output logic [AW:0]   occupancy,
    output logic          tag_err
);

    logic       fifo_empty;
    logic       fifo_full;
    logic [1:0] head_tag;
    logic       push;
    logic       ld;
    logic       xfer;
    pa_pair_t   sel_pair;
    logic       sel_valid;

    pa_tag_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (xfer),
        .din   (iss_tag),
        .head  (head_tag),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (occupancy)
    );

    // iss_ready looks only at the registered count, keeping out_ready off
    // the issue path; a pop in a full cycle therefore cannot admit a push.
    assign iss_ready = !fifo_full;
    assign push      = iss_valid && iss_ready && (iss_tag != TAG_INV);

    // Output register can take a new result when empty or being drained.
    assign ld = !out_valid || out_ready;

    assign p0_ready = !fifo_empty && (head_tag == TAG_P0) && ld;
    assign p1_ready = !fifo_empty && (head_tag == TAG_P1) && ld;
    assign p2_ready = !fifo_empty && (head_tag == TAG_P2) && ld;

    always_comb begin
        sel_pair  = '0;
        sel_valid = 1'b0;
        case (head_tag)
            TAG_P0: begin
                sel_pair  = '{a: p0_a, b: p0_b};
                sel_valid = p0_valid;
            end
            TAG_P1: begin
                sel_pair  = '{a: p1_a, b: p1_b};
                sel_valid = p1_valid;
            end
            TAG_P2: begin
                sel_pair  = '{a: p2_a, b: p2_b};
                sel_valid = p2_valid;
            end
            default: begin
                sel_pair  = '0;
                sel_valid = 1'b0;
            end
        endcase
    end

    assign xfer = sel_valid && !fifo_empty && ld;

    // Output register stage: load on transfer, otherwise drain or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_tag   <= TAG_P0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_a     <= sel_pair.a;
            out_b     <= sel_pair.b;
            out_tag   <= head_tag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // The invalid code is flagged whether or not the FIFO has room.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_err <= 1'b0;
        end else if (iss_valid && (iss_tag == TAG_INV)) begin
            tag_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pa_path_merge.sv
module tb_pa_path_merge;
    import pa_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iss_valid;
    logic [1:0]    iss_tag;
    logic          iss_ready;
    logic [2:0]    pv;
    logic          p0_ready, p1_ready, p2_ready;
    logic [2:0]    rdy;
    logic [W-1:0]  pa_d [3];
    logic [W-1:0]  pb_d [3];
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_a, out_b;
    logic [1:0]    out_tag;
    logic [AW:0]   occupancy;
    logic          tag_err;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of outstanding path codes plus the output register.
    logic [1:0]    mq [$];
    bit            m_valid;
    logic [W-1:0]  m_a, m_b;
    logic [1:0]    m_tag;
    bit            m_err;

    assign rdy = {p2_ready, p1_ready, p0_ready};

    always #5 clk = ~clk;

    pa_path_merge #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_tag   (iss_tag),
        .iss_ready (iss_ready),
        .p0_valid  (pv[0]),
        .p1_valid  (pv[1]),
        .p2_valid  (pv[2]),
        .p0_ready  (p0_ready),
        .p1_ready  (p1_ready),
        .p2_ready  (p2_ready),
        .p0_a      (pa_d[0]),
        .p0_b      (pb_d[0]),
        .p1_a      (pa_d[1]),
        .p1_b      (pb_d[1]),
        .p2_a      (pa_d[2]),
        .p2_b      (pb_d[2]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_tag   (out_tag),
        .occupancy (occupancy),
        .tag_err   (tag_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_valid = 0;
        m_a     = '0;
        m_b     = '0;
        m_tag   = 2'b00;
        m_err   = 0;
    endtask

    // Entered at posedge+1 with inputs set; returns at the next posedge+1.
    task automatic cycle();
        int h;
        bit ld;
        bit push;
        h = -1;
        #3;
        chk("iss_ready", iss_ready, (mq.size() != DEPTH));
        ld = !m_valid || out_ready;
        for (int n = 0; n < 3; n++)
            chk($sformatf("p%0d_ready", n), rdy[n],
                (mq.size() > 0 && int'(mq[0]) == n && ld));
        push = iss_valid && (mq.size() != DEPTH) && (iss_tag != TAG_INV);
        if (iss_valid && iss_tag == TAG_INV) m_err = 1;
        if (mq.size() > 0 && ld && pv[mq[0]]) begin
            h       = int'(mq[0]);
            m_a     = pa_d[h];
            m_b     = pb_d[h];
            m_tag   = mq[0];
            m_valid = 1;
            void'(mq.pop_front());
        end else if (out_ready) begin
            m_valid = 0;
        end
        if (push) mq.push_back(iss_tag);
        @(posedge clk);
        #1;
        if (h >= 0) pv[h] = 1'b0;   // the source retires its accepted result
        chk("out_valid", out_valid, m_valid);
        chk("out_a", out_a, m_a);
        chk("out_b", out_b, m_b);
        chk("out_tag", out_tag, m_tag);
        chk("occupancy", occupancy, mq.size());
        chk("tag_err", tag_err, m_err);
    endtask

    task automatic issue(input logic [1:0] t);
        iss_valid = 1'b1;
        iss_tag   = t;
        cycle();
        iss_valid = 1'b0;
    endtask

    task automatic load_path(input int n);
        pa_d[n] = W'({$urandom(), $urandom()});
        pb_d[n] = W'({$urandom(), $urandom()});
        pv[n]   = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        iss_valid = 1'b0;
        iss_tag   = 2'b00;
        pv        = 3'b000;
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            pa_d[n] = '0;
            pb_d[n] = '0;
        end
        model_reset();
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_tag_err", tag_err, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();

        // Three paths valid at once: results leave in issue order.
        issue(TAG_P0);
        issue(TAG_P1);
        issue(TAG_P2);
        for (int n = 0; n < 3; n++) load_path(n);
        repeat (5) cycle();

        // Issue path1 then path0; path0 ready early but must wait.
        issue(TAG_P1);
        issue(TAG_P0);
        load_path(0);
        repeat (2) cycle();
        load_path(1);
        repeat (4) cycle();

        // Fill the FIFO with no path activity; fifth issue is refused.
        for (int i = 0; i < 5; i++) issue(TAG_P2);
        cycle();
        load_path(2);
        cycle();
        cycle();
        // Drain the rest.
        for (int i = 0; i < 3; i++) begin
            load_path(2);
            cycle();
        end
        repeat (2) cycle();

        // Back-pressure: result held stable, no path accepted, then no gap.
        issue(TAG_P0);
        issue(TAG_P1);
        out_ready = 1'b0;
        load_path(0);
        load_path(1);
        repeat (4) cycle();
        out_ready = 1'b1;
        repeat (4) cycle();

        // Randomized traffic with valid path codes only.
        for (int i = 0; i < 400; i++) begin
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_tag   = 2'($urandom_range(0, 2));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int n = 0; n < 3; n++)
                if (!pv[n] && $urandom_range(0, 2) == 0) load_path(n);
            cycle();
        end
        iss_valid = 1'b0;
        out_ready = 1'b1;
        pv        = 3'b111;
        repeat (12) cycle();
        pv        = 3'b000;

        // Invalid code sets the sticky flag without pushing.
        issue(TAG_INV);
        issue(TAG_P1);
        load_path(1);
        repeat (3) cycle();

        // Async reset with three tags outstanding and a held result.
        for (int i = 0; i < 4; i++) issue(TAG_P0);
        out_ready = 1'b0;
        load_path(0);
        cycle();
        chk("pre_rst_out_valid", out_valid, 1'b1);
        chk("pre_rst_occupancy", occupancy, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_occupancy", occupancy, 0);
        chk("async_tag_err", tag_err, 1'b0);
        chk("async_out_a", out_a, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        pv        = 3'b111;
        repeat (3) cycle();
        pv        = 3'b000;
        issue(TAG_P2);
        load_path(2);
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
